// File: rtl/gray_sobel_pkg.sv
// Shared types and constants for the gray/Sobel frame sequencer slice.
// No logic, so it adds no latency.
// Carries no flow control of its own.
package gray_sobel_pkg;

   // Width of an RGB or bypass pixel throughout the datapath
   localparam int MAX_PIXEL_BITS = 24;

   typedef enum logic [1:0] {
      MODE_GRAY       = 2'b00,
      MODE_SOBEL      = 2'b01,
      MODE_GRAY_SOBEL = 2'b10,
      MODE_BYPASS     = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FEED  = 2'b01,
      DRAIN = 2'b10,
      DONE  = 2'b11
   } seq_state_t;

   // Modes whose results come from the Sobel core, which is qualified by px_ready
   function automatic logic mode_uses_sobel(input mode_t m);
      return (m == MODE_SOBEL) || (m == MODE_GRAY_SOBEL);
   endfunction

endpackage

// File: rtl/gray_sobel_frame_seq_if.sv
// Bundle of the frame sequencer's control, pixel stream and datapath signals.
// Wires only, so there is no latency.
// Input stream uses valid/ready; the datapath return path has no backpressure.
interface gray_sobel_frame_seq_if;
   import gray_sobel_pkg::*;

   logic                      start_frame_i;
   logic                      abort_i;
   logic [1:0]                cfg_mode_i;
   logic                      in_valid_i;
   logic [MAX_PIXEL_BITS-1:0] in_pixel_i;
   logic                      in_ready_o;
   logic [1:0]                dp_select_o;
   logic                      dp_start_o;
   logic [MAX_PIXEL_BITS-1:0] dp_pixel_o;
   logic [MAX_PIXEL_BITS-1:0] dp_pixel_i;
   logic                      dp_px_ready_i;
   logic                      out_valid_o;
   logic [MAX_PIXEL_BITS-1:0] out_pixel_o;
   logic                      busy_o;
   logic                      done_o;
   logic                      err_o;

   // The sequencer itself
   modport slave (
      input  start_frame_i, abort_i, cfg_mode_i, in_valid_i, in_pixel_i,
             dp_pixel_i, dp_px_ready_i,
      output in_ready_o, dp_select_o, dp_start_o, dp_pixel_o,
             out_valid_o, out_pixel_o, busy_o, done_o, err_o
   );

   // The surroundings: pixel source, datapath and frame controller
   modport master (
      output start_frame_i, abort_i, cfg_mode_i, in_valid_i, in_pixel_i,
             dp_pixel_i, dp_px_ready_i,
      input  in_ready_o, dp_select_o, dp_start_o, dp_pixel_o,
             out_valid_o, out_pixel_o, busy_o, done_o, err_o
   );

endinterface

// File: rtl/valid_delay_line.sv
// Shift register that delays a valid strobe by DEPTH cycles, with sync clear.
// Latency: exactly DEPTH cycles from vld_i to vld_o.
// No backpressure; busy_o reports any valid still in flight.
module valid_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk_i,
   input  logic nreset_i,
   input  logic clr_i,
   input  logic vld_i,
   output logic vld_o,
   output logic busy_o
);

   logic [DEPTH-1:0] sr_q;

   // Shift in the new valid each cycle; a clear drops everything in flight
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         sr_q <= '0;
      end else if (clr_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= DEPTH'({sr_q, vld_i});
      end
   end

   assign vld_o  = sr_q[DEPTH-1];
   assign busy_o = |sr_q;

endmodule

// File: rtl/gray_sobel_frame_seq.sv
// Frame sequencer: feeds one frame into the gray/Sobel datapath, flushes it, qualifies results.
// Latency: handshake->dp_start +1; bypass result +2; gray result +GRAY_LAT+2; Sobel result +1 after px_ready.
// Backpressure: in_ready only while feeding; results have no backpressure.
module gray_sobel_frame_seq
   import gray_sobel_pkg::*;
#(
   parameter int IMG_W         = 8,
   parameter int IMG_H         = 8,
   parameter int SOBEL_OUT_PX  = (IMG_W - 2) * (IMG_H - 2),
   parameter int GRAY_LAT      = 1,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic                  clk_i,
   input  logic                  nreset_i,
   gray_sobel_frame_seq_if.slave sif
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int CW   = $clog2(NPIX + 1);
   localparam int DW   = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_PX    = CW'(NPIX - 1);
   localparam logic [CW-1:0] SOBEL_N    = CW'(SOBEL_OUT_PX);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

   seq_state_t                state_q, state_d;
   mode_t                     mode_q, mode_d;
   logic [CW-1:0]             in_cnt_q, in_cnt_d;
   logic [CW-1:0]             out_cnt_q, out_cnt_d;
   logic [DW-1:0]             drain_cnt_q, drain_cnt_d;
   logic                      dp_start_q, dp_start_d;
   logic [MAX_PIXEL_BITS-1:0] dp_pixel_q, dp_pixel_d;
   logic                      out_valid_q, out_valid_d;
   logic [MAX_PIXEL_BITS-1:0] out_pixel_q, out_pixel_d;
   logic                      err_q, err_d;
   logic                      vdl_clr, vdl_vld, vdl_busy;
   logic                      hs, sobel_mode, frame_active, pipe_empty;

   // Gray results arrive GRAY_LAT cycles after the start strobe that produced them
   valid_delay_line #(.DEPTH(GRAY_LAT)) u_gray_vdl (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .clr_i    (vdl_clr),
      .vld_i    (dp_start_q),
      .vld_o    (vdl_vld),
      .busy_o   (vdl_busy)
   );

   assign hs           = sif.in_valid_i & (state_q == FEED);
   assign sobel_mode   = mode_uses_sobel(mode_q);
   assign frame_active = (state_q == FEED) || (state_q == DRAIN);
   // Bypass results are captured straight off dp_start, so only the start strobe matters there
   assign pipe_empty   = ~dp_start_q & ((mode_q == MODE_BYPASS) | ~vdl_busy);

   // Next state, counters, datapath drive and result qualification
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      drain_cnt_d = drain_cnt_q;
      dp_start_d  = 1'b0;
      dp_pixel_d  = dp_pixel_q;
      out_valid_d = 1'b0;
      out_pixel_d = out_pixel_q;
      err_d       = err_q;
      vdl_clr     = 1'b0;

      if (sif.abort_i) begin
         // Abort beats every transition, including a coincident start
         state_d = IDLE;
         vdl_clr = 1'b1;
      end else begin
         // Sobel results are counted; px_ready beyond the frame's quota is dropped
         if (sobel_mode) begin
            if (frame_active && sif.dp_px_ready_i && (out_cnt_q < SOBEL_N)) begin
               out_valid_d = 1'b1;
               out_cnt_d   = out_cnt_q + CW'(1);
            end
         end else if (mode_q == MODE_BYPASS) begin
            out_valid_d = dp_start_q;
         end else begin
            out_valid_d = vdl_vld;
         end
         if (out_valid_d) begin
            out_pixel_d = sif.dp_pixel_i;
         end

         case (state_q)
            IDLE: begin
               if (sif.start_frame_i) begin
                  mode_d      = mode_t'(sif.cfg_mode_i);
                  in_cnt_d    = '0;
                  out_cnt_d   = '0;
                  drain_cnt_d = '0;
                  err_d       = 1'b0;
                  vdl_clr     = 1'b1;
                  state_d     = FEED;
               end
            end
            FEED: begin
               if (hs) begin
                  in_cnt_d   = in_cnt_q + CW'(1);
                  dp_start_d = 1'b1;
                  dp_pixel_d = sif.in_pixel_i;
                  if (in_cnt_q == LAST_PX) begin
                     drain_cnt_d = '0;
                     state_d     = DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (sobel_mode ? (out_cnt_q == SOBEL_N) : pipe_empty) begin
                  state_d = DONE;
               end else if (drain_cnt_q == DRAIN_LAST) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  drain_cnt_d = drain_cnt_q + DW'(1);
                  // Zero pixels push the last window rows out of the Sobel line buffers
                  if (sobel_mode) begin
                     dp_start_d = 1'b1;
                     dp_pixel_d = '0;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q     <= IDLE;
         mode_q      <= MODE_GRAY;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         drain_cnt_q <= '0;
         dp_start_q  <= 1'b0;
         dp_pixel_q  <= '0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         dp_start_q  <= dp_start_d;
         dp_pixel_q  <= dp_pixel_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
         err_q       <= err_d;
      end
   end

   assign sif.in_ready_o  = (state_q == FEED);
   assign sif.dp_select_o = mode_q;
   assign sif.dp_start_o  = dp_start_q;
   assign sif.dp_pixel_o  = dp_pixel_q;
   assign sif.out_valid_o = out_valid_q;
   assign sif.out_pixel_o = out_pixel_q;
   assign sif.busy_o      = (state_q != IDLE);
   assign sif.done_o      = (state_q == DONE);
   assign sif.err_o       = err_q;

endmodule

// File: tb/tb_gray_sobel_frame_seq.sv
// Self-checking bench for gray_sobel_frame_seq with a behavioural datapath stub.
// Gray/bypass/Sobel frames, stream gaps, surplus px_ready, drain timeout, abort, ignored restarts.
// Expected results are queued at stimulus time and matched as out_valid beats appear.
module tb_gray_sobel_frame_seq;
   import gray_sobel_pkg::*;

   localparam int PW       = MAX_PIXEL_BITS;
   localparam int NPIX     = 64;
   localparam int SOBEL_N  = 36;
   localparam int GRAY_LAT = 1;
   localparam int TO       = 64;
   localparam logic [PW-1:0] GRAY_KEY = PW'(24'h5A3C1E);

   typedef struct {
      logic [PW-1:0] px;
      int            cyc;
   } exp_t;

   logic clk_i = 1'b0;
   logic nreset_i = 1'b0;
   gray_sobel_frame_seq_if bus();

   gray_sobel_frame_seq #(
      .IMG_W(8), .IMG_H(8), .SOBEL_OUT_PX(SOBEL_N), .GRAY_LAT(GRAY_LAT), .DRAIN_TIMEOUT(TO)
   ) dut (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .sif      (bus)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0, n_fail = 0, cyc = 0, done_cnt = 0;
   int hs_cnt, start_cnt, beat_cnt, done_base, done_cyc, last_hs_cyc, last_beat_cyc, sob_pushed;
   bit prev_hs = 1'b0;
   mode_t tb_mode = MODE_GRAY, exp_mode = MODE_GRAY;
   logic [PW-1:0] sob_pix, gray_q;
   exp_t exp_q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Datapath stub: bypass is combinational, gray is a one-cycle keyed transform, Sobel is driven by the test
   always @(posedge clk_i) gray_q <= bus.dp_pixel_o ^ GRAY_KEY;
   always_comb begin
      bus.dp_pixel_i = sob_pix;
      if (tb_mode == MODE_BYPASS) bus.dp_pixel_i = bus.dp_pixel_o;
      else if (tb_mode == MODE_GRAY) bus.dp_pixel_i = gray_q;
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   // Monitor: scoreboard push on handshake, pop on out_valid, per-cycle invariants
   always @(negedge clk_i) begin
      exp_t e;
      bit   hs;
      if (nreset_i) begin
         hs = bus.in_valid_i && bus.in_ready_o;
         if (hs) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            if (tb_mode == MODE_BYPASS)
               exp_q.push_back('{px: bus.in_pixel_i, cyc: cyc + 2});
            else if (tb_mode == MODE_GRAY)
               exp_q.push_back('{px: bus.in_pixel_i ^ GRAY_KEY, cyc: cyc + GRAY_LAT + 2});
         end
         if (bus.dp_start_o) begin
            start_cnt++;
            if (start_cnt > NPIX) chk("flush_px", bus.dp_pixel_o, 0);
         end
         if (tb_mode == MODE_GRAY || tb_mode == MODE_BYPASS)
            chk("start_mirror", bus.dp_start_o, prev_hs);
         prev_hs = hs;
         if (bus.busy_o) chk("select_hold", bus.dp_select_o, exp_mode);
         if (bus.done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.out_valid_o) begin
            beat_cnt++;
            last_beat_cyc = cyc;
            chk("beat_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_px", bus.out_pixel_o, e.px);
               chk("out_lat", cyc, e.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_frame(input mode_t m);
      hs_cnt = 0; start_cnt = 0; beat_cnt = 0; sob_pushed = 0;
      done_base = done_cnt;
      tb_mode = m; exp_mode = m;
      bus.cfg_mode_i = m;
      bus.start_frame_i = 1'b1;
      tick();
      bus.start_frame_i = 1'b0;
   endtask

   // gap: drop in_valid every 4th cycle; abort_at: abort after that many pixels; disturb: restart/mode noise
   task automatic feed_frame(input bit gap, input int abort_at, input bit disturb);
      int sent = 0;
      int t = 0;
      bit hs;
      while (sent < NPIX && t < 1000) begin
         if (abort_at >= 0 && sent == abort_at) begin
            bus.in_valid_i = 1'b0;
            bus.abort_i = 1'b1;
            tick();
            bus.abort_i = 1'b0;
            return;
         end
         bus.in_valid_i = !(gap && (t % 4 == 3));
         bus.in_pixel_i = PW'($urandom);
         if (disturb) begin
            bus.cfg_mode_i = 2'(t);
            bus.start_frame_i = (t == 10);
         end
         hs = bus.in_valid_i && bus.in_ready_o;
         tick();
         if (hs) sent++;
         t++;
      end
      bus.in_valid_i = 1'b0;
      bus.start_frame_i = 1'b0;
      bus.cfg_mode_i = exp_mode;
   endtask

   task automatic end_frame(input string tag, input int exp_beats, input int exp_starts);
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         ok = (done_cnt != done_base);
      end
      chk({tag, "_done_seen"}, 32'(ok), 1);
      chk({tag, "_busy_after_done"}, bus.busy_o, 0);
      chk({tag, "_handshakes"}, hs_cnt, NPIX);
      chk({tag, "_beats"}, beat_cnt, exp_beats);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
      if (exp_starts >= 0) chk({tag, "_starts"}, start_cnt, exp_starts);
      repeat (3) tick();
      chk({tag, "_done_pulses"}, done_cnt - done_base, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int beats0;
      bus.start_frame_i = 1'b0; bus.abort_i = 1'b0; bus.cfg_mode_i = 2'b00;
      bus.in_valid_i = 1'b0; bus.in_pixel_i = '0; bus.dp_px_ready_i = 1'b0;
      sob_pix = '0;
      hs_cnt = 0; start_cnt = 0; beat_cnt = 0; done_base = 0; sob_pushed = 0;
      done_cyc = 0; last_hs_cyc = 0; last_beat_cyc = 0;

      // Reset values
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_in_ready", bus.in_ready_o, 0);
      chk("rst_select", bus.dp_select_o, 0);
      chk("rst_dp_start", bus.dp_start_o, 0);
      chk("rst_dp_pixel", bus.dp_pixel_o, 0);
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_out_pixel", bus.out_pixel_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_done", bus.done_o, 0);
      chk("rst_err", bus.err_o, 0);
      nreset_i = 1'b1;
      tick();

      // Gray frame, stream never pauses
      start_frame(MODE_GRAY);
      chk("gray_busy", bus.busy_o, 1);
      feed_frame(1'b0, -1, 1'b0);
      end_frame("gray", NPIX, NPIX);

      // Bypass frame with a pause every 4th cycle
      start_frame(MODE_BYPASS);
      feed_frame(1'b1, -1, 1'b0);
      end_frame("bypass_gap", NPIX, NPIX);

      // Sobel frame: stub raises px_ready 40 times once 40 pixels are in
      start_frame(MODE_SOBEL);
      fork
         feed_frame(1'b0, -1, 1'b0);
         begin
            for (int g = 0; g < 200 && hs_cnt < 40; g++) tick();
            for (int i = 0; i < 40; i++) begin
               bus.dp_px_ready_i = 1'b1;
               sob_pix = PW'($urandom);
               if (sob_pushed < SOBEL_N) begin
                  exp_q.push_back('{px: sob_pix, cyc: cyc + 1});
                  sob_pushed++;
               end
               tick();
            end
            bus.dp_px_ready_i = 1'b0;
         end
      join
      end_frame("sobel", SOBEL_N, -1);
      chk("sobel_flush_seen", 32'(start_cnt > NPIX), 1);
      chk("sobel_done_after_last", done_cyc - last_beat_cyc, 1);
      chk("sobel_err", bus.err_o, 0);

      // Sobel frame with no px_ready at all: drain timeout
      start_frame(MODE_SOBEL);
      feed_frame(1'b0, -1, 1'b0);
      end_frame("timeout", 0, -1);
      chk("timeout_drain_len", done_cyc - last_hs_cyc, TO + 1);
      chk("timeout_err", bus.err_o, 1);

      // Next start clears the sticky error; frame completes normally
      start_frame(MODE_GRAY);
      chk("err_cleared", bus.err_o, 0);
      feed_frame(1'b0, -1, 1'b0);
      end_frame("gray_after_err", NPIX, NPIX);

      // Abort after 20 gray pixels
      start_frame(MODE_GRAY);
      feed_frame(1'b0, 20, 1'b0);
      chk("abort_busy", bus.busy_o, 0);
      chk("abort_dp_start", bus.dp_start_o, 0);
      chk("abort_done", bus.done_o, 0);
      exp_q.delete();
      beats0 = beat_cnt;
      repeat (6) tick();
      chk("abort_no_done", done_cnt - done_base, 0);
      chk("abort_no_beats", beat_cnt - beats0, 0);

      start_frame(MODE_GRAY);
      feed_frame(1'b0, -1, 1'b0);
      end_frame("gray_after_abort", NPIX, NPIX);

      // Bypass frame with a restart request and mode toggling mid-frame
      start_frame(MODE_BYPASS);
      feed_frame(1'b0, -1, 1'b1);
      end_frame("disturb", NPIX, NPIX);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_sobel_frame_seq.md
Name: gray_sobel_frame_seq

Overview:
- Frame-level sequencer for the gray/Sobel datapath top.
- Accepts one frame of pixels on a valid/ready stream and latches the processing mode for the whole frame.
- Drives the datapath's select/start/pixel inputs, flushes the Sobel pipeline at end of frame, and qualifies datapath outputs with a valid strobe.
- Signals frame done, or an error on drain timeout.

Parameters:
- IMG_W, 8, frame width in pixels (>=3)
- IMG_H, 8, frame height in pixels (>=3)
- SOBEL_OUT_PX, (IMG_W-2)*(IMG_H-2), expected Sobel output pixels per frame
- GRAY_LAT, 1, gray core latency in cycles from start to output
- DRAIN_TIMEOUT, 64, max DRAIN cycles before error
- MAX_PIXEL_BITS, from shared parameters header, RGB/bypass pixel width

Ports:
- clk_i  in  1  clock
- nreset_i  in  1  async active-low reset
- start_frame_i  in  1  pulse: begin frame; ignored unless IDLE
- abort_i  in  1  sync abort, any state
- cfg_mode_i  in  2  00 gray, 01 sobel, 10 gray+sobel, 11 bypass; sampled at start
- in_valid_i  in  1  input pixel valid
- in_pixel_i  in  MAX_PIXEL_BITS  input pixel
- in_ready_o  out  1  sequencer accepts pixel
- dp_select_o  out  2  to datapath select
- dp_start_o  out  1  to datapath start
- dp_pixel_o  out  MAX_PIXEL_BITS  to datapath pixel
- dp_pixel_i  in  MAX_PIXEL_BITS  from datapath output pixel
- dp_px_ready_i  in  1  from datapath Sobel ready
- out_valid_o  out  1  out_pixel_o holds a valid result
- out_pixel_o  out  MAX_PIXEL_BITS  result pixel
- busy_o  out  1  high outside IDLE
- done_o  out  1  one-cycle pulse at frame end
- err_o  out  1  sticky drain timeout; cleared by next start_frame_i

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; mode_q = 00.
- FSM states:
  - IDLE: start_frame_i -> mode_q <= cfg_mode_i, clear counters and err_o, go to FEED.
  - FEED: in_ready_o = 1 (combinational, state==FEED). Handshake = in_valid_i & in_ready_o. Each handshake increments in_cnt. After the handshake with in_cnt == IMG_W*IMG_H-1, go to DRAIN.
  - DRAIN: for modes 01/10, dp_start_o = 1 and dp_pixel_o = 0 (flush) until out_cnt == SOBEL_OUT_PX. For modes 00/11, wait until the valid pipeline is empty. Then go to DONE.
  - DONE: done_o = 1 for one cycle, then IDLE.
- dp_select_o = mode_q, registered. It is stable for the whole frame including DRAIN/DONE; the datapath muxes combinationally on select.
- dp_start_o / dp_pixel_o are registered one cycle after the handshake. A cycle with no handshake in FEED gives dp_start_o = 0 (stream pause).
- Output qualification, registered:
  - Modes 01/10: out_valid_o = dp_px_ready_i & (out_cnt < SOBEL_OUT_PX). Surplus px_ready pulses are ignored and not counted.
  - Mode 00: out_valid_o follows dp_start_o delayed GRAY_LAT cycles.
  - Mode 11: out_valid_o follows dp_start_o delayed 1 cycle.
  - out_pixel_o captures dp_pixel_i when out_valid_o rises. Otherwise out_pixel_o holds its value.
- Latency: handshake -> dp_start_o +1; bypass result +2; gray result +1+GRAY_LAT+1.
- DRAIN timeout: drain_cnt reaches DRAIN_TIMEOUT -> err_o = 1, done_o still pulses, go to DONE.
- abort_i has priority over all transitions. Next cycle: IDLE, dp_start_o = 0, valid pipeline cleared, no done_o.
- start_frame_i coincident with abort_i: abort wins.
- Counter widths: $clog2(IMG_W*IMG_H+1). No wrap within a frame.
- Reset mid-frame: immediate return to reset values.

Decomposition:
- Shared package gray_sobel_pkg holds:
  - mode_t enum (MODE_GRAY=00, MODE_SOBEL=01, MODE_GRAY_SOBEL=10, MODE_BYPASS=11)
  - seq_state_t enum (IDLE, FEED, DRAIN, DONE)
- One sub-module, valid_delay_line: parameterised-depth shift register for valid, with sync clear. Used for the gray/bypass latency.

Test Plan:
- Gray 8x8, in_valid_i held high:
  - 64 handshakes.
  - dp_start_o high for 64 cycles.
  - 64 out_valid_o beats, first at handshake+3 (GRAY_LAT=1).
  - done_o single pulse.
  - busy_o low the cycle after DONE.
- Bypass 8x8 with in_valid_i low every 4th cycle:
  - dp_start_o gaps mirror the input gaps.
  - out_pixel_o sequence equals the input pixels in order, each 2 cycles after its handshake.
  - 64 valid beats.
- Sobel 8x8 (mode 01), stub asserts dp_px_ready_i 40 times:
  - DRAIN flushes with dp_pixel_o = 0.
  - out_valid_o counts exactly 36.
  - 4 surplus pulses ignored.
  - done_o after the 36th beat.
- Sobel stub never asserts px_ready:
  - err_o = 1 after 64 DRAIN cycles, done_o pulses.
  - Next start_frame_i clears err_o.
- abort_i at pixel 20 of gray frame:
  - Next cycle IDLE, dp_start_o = 0, no done_o.
  - A following frame completes normally.
- start_frame_i while busy, and cfg_mode_i toggled mid-frame:
  - Both ignored.
  - dp_select_o holds the latched mode until DONE.
